// File: rtl/mat_mul_stream_pkg.sv
// mat_mul_pkg: shared states, defaults and address helper for mat_mul_stream.
package mat_mul_pkg;
    localparam int DEF_DIM_LOG = 1;
    localparam int DEF_DATA_WIDTH = 32;
    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;
    function automatic logic [9:0] idx2addr(input logic [4:0] hi, input logic [4:0] lo, input int dim_log);
        return (10'(hi) << dim_log) | 10'(lo);
    endfunction
endpackage

// File: rtl/mat_mul_stream_sdp_ram.sv
// sdp_ram: simple dual-port RAM, synchronous write and 1-cycle synchronous read, no reset.
module sdp_ram #(
    parameter int AW = 2,
    parameter int DW = 32
) (
    input  logic          s00_axi_aclk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);
    logic [DW-1:0] mem [2**AW];
    always_ff @(posedge s00_axi_aclk) begin
        if (we) mem[wa] <= wd;
        rd <= mem[ra];
    end
endmodule

// File: rtl/mat_mul_stream.sv
// mat_mul_stream: AXI-Stream DIM x DIM matrix multiplier with persistent operands,
// a 3-stage single-MAC datapath and a skid-buffered result stream.
module mat_mul_stream
    import mat_mul_pkg::*;
#(
    parameter int DIM_LOG = DEF_DIM_LOG,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DIM = 2**DIM_LOG,
    parameter int SIZE = DIM*DIM,
    parameter int SIZE_LOG = 2*DIM_LOG,
    parameter int ACC_WIDTH = 2*DATA_WIDTH+DIM_LOG
) (
    input  logic                    s00_axi_aclk,
    input  logic                    s00_axi_aresetn,
    output logic                    s00_axis_tready,
    input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic                    s00_axis_tlast,
    input  logic                    s00_axis_tvalid,
    output logic                    m00_axis_tvalid,
    output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                    m00_axis_tlast,
    input  logic                    m00_axis_tready,
    input  logic                    sel,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    err_len
);
    localparam logic [SIZE_LOG:0] SZ = (SIZE_LOG+1)'(SIZE);
    localparam logic [SIZE_LOG:0] SZ_M1 = (SIZE_LOG+1)'(SIZE-1);
    localparam logic [DIM_LOG-1:0] DMAX = '1;
    state_t state, state_nxt;
    logic rdy_en, start_q, start_rise, beat, tgt, sel_q, wr_ok;
    logic [SIZE_LOG:0] ld_cnt, beat_idx, rd_cnt;
    logic [DIM_LOG-1:0] r, c, k;
    logic iss, iss_done, iss_fin, v1, first1, last1, fin1, wr2, fin2;
    logic [SIZE_LOG-1:0] a_ra, b_ra, rc_addr, addr1, addr2;
    logic [ACC_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] a_rd, b_rd, r_rd, od, sd;
    logic rd_iss, rdv, rdl, ov, ol, sv, sl, pop, hold;
    assign s00_axis_tready = rdy_en && (state == IDLE || state == LOAD);
    assign beat = s00_axis_tvalid && s00_axis_tready;
    assign start_rise = start && !start_q;
    assign beat_idx = (state == IDLE) ? '0 : ld_cnt;
    assign tgt = (state == IDLE) ? sel : sel_q;
    assign wr_ok = beat && (beat_idx < SZ);
    assign iss = (state == COMPUTE) && !iss_done;
    assign iss_fin = (r == DMAX) && (c == DMAX) && (k == DMAX);
    assign a_ra = SIZE_LOG'(idx2addr(5'(r), 5'(k), DIM_LOG));
    assign b_ra = SIZE_LOG'(idx2addr(5'(k), 5'(c), DIM_LOG));
    assign rc_addr = SIZE_LOG'(idx2addr(5'(r), 5'(c), DIM_LOG));
    assign pop = ov && m00_axis_tready;
    assign hold = ov && !pop;
    // Issue a read only if the output/skid pair can absorb it next cycle.
    assign rd_iss = (state == DRAIN) && (rd_cnt < SZ) && !(hold && sv) && !(hold && rdv) && !(sv && rdv);
    assign m00_axis_tvalid = ov;
    assign m00_axis_tdata = od;
    assign m00_axis_tlast = ov && ol;
    assign m00_axis_tstrb = '1;
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn)
        if (!s00_axi_aresetn) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        busy = state != IDLE;
        case (state)
            IDLE:    state_nxt = beat ? (s00_axis_tlast ? IDLE : LOAD) : (start_rise ? COMPUTE : IDLE);
            LOAD:    state_nxt = (beat && s00_axis_tlast) ? IDLE : LOAD;
            COMPUTE: state_nxt = fin2 ? DRAIN : COMPUTE;
            DRAIN:   state_nxt = (pop && ol) ? IDLE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn)
        if (!s00_axi_aresetn) begin
            {rdy_en, start_q, sel_q, done, err_len, iss_done} <= '0;
            {r, c, k, ld_cnt, rd_cnt} <= '0;
            {v1, first1, last1, fin1, wr2, fin2, addr1, addr2, acc} <= '0;
            {rdv, rdl, ov, ol, sv, sl, od, sd} <= '0;
        end else begin
            rdy_en <= 1'b1;
            start_q <= start;
            if (beat) ld_cnt <= (beat_idx == SZ) ? SZ : beat_idx + 1'b1;
            if (beat && state == IDLE) sel_q <= sel;
            if (beat && state == IDLE) err_len <= 1'b0;
            if (beat && s00_axis_tlast) err_len <= beat_idx != SZ_M1;
            if (state == IDLE && (beat || start_rise)) done <= 1'b0;
            if (pop && ol) done <= 1'b1;
            if (state != COMPUTE) begin
                {r, c, k, iss_done} <= '0;
            end else if (!iss_done) begin
                k <= k + 1'b1;
                if (k == DMAX) c <= c + 1'b1;
                if (k == DMAX && c == DMAX) r <= r + 1'b1;
                iss_done <= iss_fin;
            end
            v1 <= iss;
            first1 <= k == '0;
            last1 <= k == DMAX;
            fin1 <= iss && iss_fin;
            addr1 <= rc_addr;
            if (v1) acc <= (first1 ? '0 : acc) + ACC_WIDTH'(a_rd) * ACC_WIDTH'(b_rd);
            wr2 <= v1 && last1;
            fin2 <= fin1;
            addr2 <= addr1;
            if (state != DRAIN) rd_cnt <= '0;
            else if (rd_iss) rd_cnt <= rd_cnt + 1'b1;
            rdv <= rd_iss;
            rdl <= rd_iss && rd_cnt == SZ_M1;
            if (!ov || pop) begin
                if (sv) begin
                    {ov, od, ol} <= {1'b1, sd, sl};
                    {sv, sd, sl} <= {rdv, r_rd, rdl};
                end else begin
                    ov <= rdv;
                    if (rdv) {od, ol} <= {r_rd, rdl};
                end
            end else if (rdv) begin
                {sv, sd, sl} <= {1'b1, r_rd, rdl};
            end
        end
    sdp_ram #(.AW(SIZE_LOG), .DW(DATA_WIDTH)) u_ram_a (
        .s00_axi_aclk(s00_axi_aclk), .we(wr_ok && !tgt), .wa(SIZE_LOG'(beat_idx)),
        .wd(s00_axis_tdata), .ra(a_ra), .rd(a_rd)
    );
    sdp_ram #(.AW(SIZE_LOG), .DW(DATA_WIDTH)) u_ram_b (
        .s00_axi_aclk(s00_axi_aclk), .we(wr_ok && tgt), .wa(SIZE_LOG'(beat_idx)),
        .wd(s00_axis_tdata), .ra(b_ra), .rd(b_rd)
    );
    sdp_ram #(.AW(SIZE_LOG), .DW(DATA_WIDTH)) u_ram_r (
        .s00_axi_aclk(s00_axi_aclk), .we(wr2), .wa(addr2),
        .wd(acc[DATA_WIDTH-1:0]), .ra(rd_cnt[SIZE_LOG-1:0]), .rd(r_rd)
    );
endmodule
